// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning block.
package btn_pkg;

  typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} btn_db_state_e;

  localparam int BTN_D       = 0;
  localparam int BTN_R       = 1;
  localparam int BTN_L       = 2;
  localparam int BTN_U       = 3;
  localparam int BTN_C       = 4;
  localparam int NUM_BTN_DEF = 5;

  typedef struct packed {
    logic lvl;
    logic prs;
    logic rel;
    logic rpt;
  } btn_evt_t;

  // One spare bit so terminal-count compares never alias
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_debounce_if.sv
// Raw pad inputs and conditioned button buses between pads and the peripheral.
interface btn_debounce_if
  import btn_pkg::*;
#(
  parameter int NUM_BTN = NUM_BTN_DEF
);
  logic [NUM_BTN-1:0] btn_raw_i;
  logic [NUM_BTN-1:0] btn_level_o;
  logic [NUM_BTN-1:0] btn_press_o;
  logic [NUM_BTN-1:0] btn_release_o;
  logic [NUM_BTN-1:0] btn_repeat_o;

  modport slave  (input  btn_raw_i,
                  output btn_level_o, btn_press_o, btn_release_o, btn_repeat_o);
  modport master (output btn_raw_i,
                  input  btn_level_o, btn_press_o, btn_release_o, btn_repeat_o);
endinterface

// File: rtl/btn_debounce_chan.sv
// One button channel: 2-FF sync, counter debounce FSM, edge and auto-repeat pulses.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int DB_CYCLES    = 1000000,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 40000000,
  parameter int REPEAT_RATE  = 10000000,
  parameter int CNT_W        = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE)
) (
  input  logic     btn_clk_i,
  input  logic     btn_rst_i,
  input  logic     raw,
  output btn_evt_t evt
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             s;
  btn_db_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d, rel_d, press_q, rel_q, rpt_q;
  logic             st, db_done;

  assign s       = sync_q[1];
  assign st      = (state_q == HELD) || (state_q == RELEASING);
  assign db_done = (cnt_q == DB_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      IDLE:      if (s) begin
                   state_d = ARMING;
                   cnt_d   = cnt_q + CNT_W'(1);
                 end
      ARMING:    if (!s)          state_d = IDLE;
                 else if (db_done) begin
                   state_d = HELD;
                   press_d = 1'b1;
                 end else          cnt_d = cnt_q + CNT_W'(1);
      HELD:      if (!s) begin
                   state_d = RELEASING;
                   cnt_d   = cnt_q + CNT_W'(1);
                 end
      RELEASING: if (s)           state_d = HELD;
                 else if (db_done) begin
                   state_d = IDLE;
                   rel_d   = 1'b1;
                 end else          cnt_d = cnt_q + CNT_W'(1);
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge btn_clk_i or posedge btn_rst_i) begin
    if (btn_rst_i) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  generate
    if (REPEAT_EN != 0) begin : g_rpt
      localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY - 1);
      localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
      logic [CNT_W-1:0] rpt_cnt_q;
      logic             first_q, hold_entry;

      // Any entry into HELD (press or a bounce back from RELEASING) restarts the delay
      assign hold_entry = (state_d == HELD) && (state_q != HELD);

      always_ff @(posedge btn_clk_i or posedge btn_rst_i) begin
        if (btn_rst_i) begin
          rpt_cnt_q <= '0;
          first_q   <= 1'b1;
          rpt_q     <= 1'b0;
        end else begin
          rpt_q <= 1'b0;
          if (!st || rel_d || hold_entry) begin
            rpt_cnt_q <= '0;
            first_q   <= 1'b1;
          end else if (rpt_cnt_q == (first_q ? DLY_LAST : RATE_LAST)) begin
            rpt_q     <= 1'b1;
            rpt_cnt_q <= '0;
            first_q   <= 1'b0;
          end else begin
            rpt_cnt_q <= rpt_cnt_q + CNT_W'(1);
          end
        end
      end
    end else begin : g_no_rpt
      assign rpt_q = 1'b0;
    end
  endgenerate

  assign evt.lvl = st;
  assign evt.prs = press_q;
  assign evt.rel = rel_q;
  assign evt.rpt = rpt_q;

endmodule

// File: rtl/btn_debounce.sv
// Nexys push-button conditioner: NUM_BTN independent debounce channels.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int NUM_BTN      = NUM_BTN_DEF,
  parameter int DB_CYCLES    = 1000000,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 40000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic           btn_clk_i,
  input  logic           btn_rst_i,
  btn_debounce_if.slave  bus
);
  localparam int CNT_W = cnt_width(DB_CYCLES, REPEAT_DELAY, REPEAT_RATE);

  btn_evt_t [NUM_BTN-1:0] evt;

  generate
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
      btn_debounce_chan #(
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_EN    (REPEAT_EN),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .CNT_W        (CNT_W)
      ) u_chan (
        .btn_clk_i (btn_clk_i),
        .btn_rst_i (btn_rst_i),
        .raw       (bus.btn_raw_i[g]),
        .evt       (evt[g])
      );
      assign bus.btn_level_o[g]   = evt[g].lvl;
      assign bus.btn_press_o[g]   = evt[g].prs;
      assign bus.btn_release_o[g] = evt[g].rel;
      assign bus.btn_repeat_o[g]  = evt[g].rpt;
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboarded bench for btn_debounce with DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3.
module tb_btn_debounce;
  import btn_pkg::*;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] raw = '0;

  always #5 clk = ~clk;

  btn_debounce_if #(.NUM_BTN(NB)) bus    ();
  btn_debounce_if #(.NUM_BTN(NB)) bus_nr ();
  assign bus.btn_raw_i    = raw;
  assign bus_nr.btn_raw_i = raw;

  btn_debounce #(.NUM_BTN(NB), .DB_CYCLES(4), .REPEAT_EN(1),
                 .REPEAT_DELAY(8), .REPEAT_RATE(3)) dut (
    .btn_clk_i (clk), .btn_rst_i (rst), .bus (bus));

  btn_debounce #(.NUM_BTN(NB), .DB_CYCLES(4), .REPEAT_EN(0),
                 .REPEAT_DELAY(8), .REPEAT_RATE(3)) dut_nr (
    .btn_clk_i (clk), .btn_rst_i (rst), .bus (bus_nr));

  typedef struct packed {
    logic [NB-1:0] lvl, prs, rel, rpt;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  function automatic obs_t sample();
    obs_t o;
    o.lvl = bus.btn_level_o;
    o.prs = bus.btn_press_o;
    o.rel = bus.btn_release_o;
    o.rpt = bus.btn_repeat_o;
    return o;
  endfunction

  function automatic obs_t sample_nr();
    obs_t o;
    o.lvl = bus_nr.btn_level_o;
    o.prs = bus_nr.btn_press_o;
    o.rel = bus_nr.btn_release_o;
    o.rpt = bus_nr.btn_repeat_o;
    return o;
  endfunction

  task automatic cyc(input logic [NB-1:0] r);
    raw = r;
    @(posedge clk); #1;
    obs_q.push_back(sample());
  endtask

  task automatic idle(input int n);
    raw = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    raw = '1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (sample() !== '0 || sample_nr() !== '0) begin
      tests_failed++;
      $display("FAIL reset_held got=%b/%b want=0", sample(), sample_nr());
    end
    raw = '0;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    tests_run++;
    if (sample() !== '0 || sample_nr() !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle got=%b/%b want=0", sample(), sample_nr());
    end
  endtask

  task automatic test_press();
    for (int k = 0; k < 16; k++) begin
      obs_t e;
      e = '0;
      e.lvl[BTN_D] = (k >= 5 && k <= 10);
      e.prs[BTN_D] = (k == 5);
      e.rel[BTN_D] = (k == 11);
      exp_q.push_back(e);
      cyc(k < 6 ? NB'(1) : NB'(0));
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL press k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] bseq;
    bseq = 5'b01101;
    for (int k = 0; k < 22; k++) begin
      obs_t          e;
      logic [NB-1:0] r;
      e = '0;
      r = '0;
      e.lvl[BTN_L] = (k >= 10 && k <= 16);
      e.prs[BTN_L] = (k == 10);
      e.rel[BTN_L] = (k == 17);
      r[BTN_L]     = (k < 5) ? bseq[k] : (k < 12);
      exp_q.push_back(e);
      cyc(r);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL bounce k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  // Release lands on the cycle a rate pulse would otherwise fire
  task automatic test_repeat();
    for (int k = 0; k < 30; k++) begin
      obs_t          e;
      logic [NB-1:0] r;
      e = '0;
      r = '0;
      e.lvl[BTN_U] = (k >= 5 && k <= 21);
      e.prs[BTN_U] = (k == 5);
      e.rel[BTN_U] = (k == 22);
      e.rpt[BTN_U] = (k == 13 || k == 16 || k == 19);
      r[BTN_U]     = (k < 17);
      exp_q.push_back(e);
      cyc(r);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL repeat k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 22; k++) begin
      obs_t          e;
      logic [NB-1:0] r;
      e = '0;
      r = '0;
      e.lvl[BTN_C] = (k >= 5 && k <= 16);
      e.lvl[BTN_R] = (k >= 5 && k <= 10);
      e.prs[BTN_C] = (k == 5);
      e.prs[BTN_R] = (k == 5);
      e.rel[BTN_R] = (k == 11);
      e.rel[BTN_C] = (k == 17);
      e.rpt[BTN_C] = (k == 13 || k == 16);
      r[BTN_C]     = (k < 12);
      r[BTN_R]     = (k < 6);
      exp_q.push_back(e);
      cyc(r);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL simul k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      obs_t e;
      e = '0;
      e.lvl[BTN_D] = (k >= 5);
      e.prs[BTN_D] = (k == 5);
      exp_q.push_back(e);
      cyc(NB'(1));
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (sample() !== '0 || sample_nr() !== '0) begin
      tests_failed++;
      $display("FAIL rst_async got=%b/%b want=0", sample(), sample_nr());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 11; k++) begin
      obs_t e;
      e = '0;
      e.lvl[BTN_D] = (k >= 5);
      e.prs[BTN_D] = (k == 5);
      exp_q.push_back(e);
      cyc(NB'(1));
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL rst_mid k=%0d got=%b want=%b", k, o, e);
      end
    end
  endtask

  task automatic test_no_repeat();
    int n_press, press_k, n_rpt_ref;
    n_press   = 0;
    press_k   = -1;
    n_rpt_ref = 0;
    for (int k = 0; k < 50; k++) begin
      raw = NB'(1) << BTN_U;
      @(posedge clk); #1;
      tests_run++;
      if (bus_nr.btn_repeat_o !== '0) begin
        tests_failed++;
        $display("FAIL norpt k=%0d got=%b want=0", k, bus_nr.btn_repeat_o);
      end
      if (bus_nr.btn_press_o[BTN_U] === 1'b1) begin
        n_press++;
        press_k = k;
      end
      if (bus.btn_repeat_o[BTN_U] === 1'b1) n_rpt_ref++;
    end
    tests_run++;
    if (n_press !== 1 || press_k !== 5) begin
      tests_failed++;
      $display("FAIL norpt_press got count=%0d at=%0d want count=1 at=5", n_press, press_k);
    end
    tests_run++;
    if (n_rpt_ref !== 13) begin
      tests_failed++;
      $display("FAIL rpt_count got=%0d want=13", n_rpt_ref);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    idle(4);
    test_bounce();
    idle(4);
    test_repeat();
    idle(4);
    test_simultaneous();
    idle(4);
    test_reset_mid();
    idle(12);
    test_no_repeat();
    idle(12);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Conditions the five raw Nexys push-buttons {BTNC,BTNU,BTNL,BTNR,BTND} before they reach the button Wishbone peripheral. Per button, it provides:
- a 2-FF synchronizer;
- a counter-based debouncer;
- press/release edge pulses;
- an optional auto-repeat pulse for held buttons (continuous player movement).

The debounced level bus drives the peripheral's btn_data input. The pulse buses are available to the interrupt/event logic.

Parameters:
- NUM_BTN, 5: number of button channels.
- DB_CYCLES, 1000000: consecutive stable synchronized samples required to accept a new level (10 ms at 100 MHz). Legal range is ≥2.
- REPEAT_EN, 1: 1 enables auto-repeat pulses; 0 ties btn_repeat_o to 0.
- REPEAT_DELAY, 40000000: cycles a button must be held after the press pulse before the first repeat pulse. Must be ≥1.
- REPEAT_RATE, 10000000: cycles between subsequent repeat pulses. Must be ≥1.
- CNT_W, $clog2(max(DB_CYCLES,REPEAT_DELAY,REPEAT_RATE))+1: counter width (derived, not overridden).

Ports:
- btn_clk_i  in  1  system clock.
- btn_rst_i  in  1  asynchronous, active-high reset.
- btn_raw_i  in  NUM_BTN  raw asynchronous pad inputs, active-high. Bit mapping: [4]=C, [3]=U, [2]=L, [1]=R, [0]=D.
- btn_level_o  out  NUM_BTN  debounced level; feeds btn_data of the button peripheral.
- btn_press_o  out  NUM_BTN  one-cycle pulse on accepted 0→1.
- btn_release_o  out  NUM_BTN  one-cycle pulse on accepted 1→0.
- btn_repeat_o  out  NUM_BTN  one-cycle auto-repeat pulse while held.

Behaviour:
- Reset values: btn_rst_i is asynchronous, active-high; clock is btn_clk_i. Reset clears to 0:
  - sync FFs,
  - stable state,
  - all counters,
  - first-repeat flag (set to 1),
  - all four output buses.
- Synchronizer: s = raw delayed by 2 btn_clk_i edges. No logic between the two FFs.
- Debounce, per channel, with stable state st and counter c, each edge:
  - s==st: c<=0.
  - s!=st and c==DB_CYCLES-1: st<=s, c<=0, and press (s=1) or release (s=0) pulses for exactly the next cycle.
  - otherwise: c<=c+1.
- Latency: a clean input step is reflected on btn_level_o after 2+DB_CYCLES edges. The press/release pulse is high during the first cycle the new level is visible.
- Bounce: any sample with s==st before the count completes resets c to 0, so the full DB_CYCLES window restarts. Pulses shorter than DB_CYCLES never reach btn_level_o.
- Channel FSM (per button), states IDLE, ARMING, HELD, RELEASING:
  - IDLE (st=0, c=0): s=1 → ARMING.
  - ARMING: s=0 → IDLE; count done → HELD (press).
  - HELD: s=0 → RELEASING.
  - RELEASING: s=1 → HELD; count done → IDLE (release).
- Auto-repeat (REPEAT_EN=1), using repeat counter r and first flag f:
  - Entering HELD: r<=0, f<=1.
  - While in HELD or RELEASING (st=1), r increments each cycle.
  - When r == (f ? REPEAT_DELAY : REPEAT_RATE)-1: repeat pulses one cycle, r<=0, f<=0.
  - The press-pulse cycle never carries a repeat pulse.
  - Leaving HELD via release: r<=0, f<=1, and no repeat pulse is issued in the release cycle.
- Simultaneous events: channels are fully independent. Any combination of press, release and repeat across channels may occur in the same cycle. Within one channel, press and release are mutually exclusive.
- Reset mid-operation: all state clears immediately and outputs drop to 0 asynchronously. After deassertion, a button still held produces a fresh press after 2+DB_CYCLES edges.
- Counter widths: counters saturate never. Compares use full CNT_W width with no truncation.

Decomposition:
- Package btn_pkg:
  - enum btn_db_state_e {IDLE, ARMING, HELD, RELEASING};
  - bit-index constants BTN_D=0, BTN_R=1, BTN_L=2, BTN_U=3, BTN_C=4;
  - NUM_BTN_DEF=5.
- Sub-module btn_debounce_chan: one channel containing the sync FFs, debounce FSM, counters and pulse registers.
- btn_debounce instantiates NUM_BTN copies via a generate loop.

Test Plan (all scenarios use DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3):
1. Reset released, raw=0 → all outputs 0. Raw[0] steps 0→1 at edge 0 → level[0]=1 and press[0]=1 for exactly one cycle starting after edge 6. Other bits stay 0.
2. Raw[2] bounces 1,0,1,1,0 (one cycle each), then holds 1 → no level change during the bounce. Level[2] rises 6 edges after the final stable 1, with a single press pulse.
3. Raw[3] held high → press at T. Repeat[3] pulses at T+8, T+11, T+14. Raw drops → release after 6 edges, with no repeat on or after the release cycle.
4. Raw[4] and raw[1] step high on the same edge, and raw[1] releases later → both presses coincide. Release[1] pulses alone while level[4] remains 1.
5. Raw[0] held high with level=1 and btn_rst_i pulsed mid-hold → outputs 0 immediately. After deassertion, a fresh press occurs 6 edges later.
6. REPEAT_EN=0, raw[3] held for 50 cycles → btn_repeat_o stays 0 throughout, and the press pulse appears once.
